// File: rtl/rr_grant_decoder_arb.sv
// rr_grant_decoder_arb: four-way round-robin arbiter with registered one-hot grant; define RR_ARB_TIMEOUT_EN to force handoff after MAX_HOLD cycles
module rr_grant_decoder_arb #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, id_n, win;
  logic [3:0] others, pool;
  logic v_n, take, drop, to;
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    w = p;
    for (int k = 3; k >= 0; k--) if (r[p + 2'(k)]) w = p + 2'(k);
    return w;
  endfunction
  // winner search from ptr and the grant/handoff/release decision
  always_comb begin
    others = req & ~(4'b0001 << grant_id);
    take = (state == IDLE) ? |req : (!req[grant_id] || to) && |others;
    drop = (state == OWNED) && !req[grant_id] && !(|others);
    pool = (state == IDLE) ? req : others;
    win = pick(pool, ptr);
    state_n = take ? OWNED : drop ? IDLE : state;
    ptr_n = take ? win + 2'd1 : ptr;
    id_n = take ? win : grant_id;
    v_n = take | (grant_valid & ~drop);
  end
`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt;
  assign to = cnt == HOLD_LAST;
  // hold counter: clears on each new grant, saturates at the last allowed cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (take) cnt <= '0;
    else if (state == OWNED && !to) cnt <= cnt + 8'd1;
`else
  logic unused_hold;
  assign unused_hold = |8'(MAX_HOLD);
  assign to = 1'b0;
`endif
  // state, pointer and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant_id <= id_n;
      grant_valid <= v_n;
      grant <= v_n ? 4'b0001 << id_n : 4'b0000;
    end
endmodule
